// File: rtl/saa1099_bus_writer_pkg.sv
// saa1099_pkg: shared types, register map and helpers for the SAA1099 bus writer
// Contents:
//   saa_bus_state_t  bus-cycle FSM states
//   saa_phase_t      address or data phase of one request
//   saa_wr_req_t     queued write request (register index + value)
//   SAA_*            SAA1099 register indices
//   max3             largest of three integers, used to size the wait counter
package saa1099_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} saa_bus_state_t;

    typedef enum logic {PH_ADDR, PH_DATA} saa_phase_t;

    // 'reg' is a keyword, so the register index field is called addr
    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } saa_wr_req_t;

    localparam logic [4:0] SAA_AMP0     = 5'h00;
    localparam logic [4:0] SAA_FREQ0    = 5'h08;
    localparam logic [4:0] SAA_OCT10    = 5'h10;
    localparam logic [4:0] SAA_FREQEN   = 5'h14;
    localparam logic [4:0] SAA_NOISEEN  = 5'h15;
    localparam logic [4:0] SAA_NOISEGEN = 5'h16;
    localparam logic [4:0] SAA_ENV0     = 5'h18;
    localparam logic [4:0] SAA_ENV1     = 5'h19;
    localparam logic [4:0] SAA_CTRL     = 5'h1C;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/saa1099_bus_writer_if.sv
// saa1099_bus_writer_if: request stream, status and SAA1099 chip bus of the bus writer
// Signals:
//   req_valid/req_ready/req_reg/req_data  write request stream
//   flush                                 discard queued requests, invalidate address cache
//   busy/level                            writer status and FIFO occupancy
//   cs_n/a0/wr_n/dout                     SAA1099 register port
// Modports: master = request source / bus observer, slave = the writer itself
interface saa1099_bus_writer_if #(
    parameter int FIFO_DEPTH = 8
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_reg;
    logic [7:0]    req_data;
    logic          flush;
    logic          busy;
    logic [LW-1:0] level;
    logic          cs_n;
    logic          a0;
    logic          wr_n;
    logic [7:0]    dout;

    modport master (
        output req_valid, req_reg, req_data, flush,
        input  req_ready, busy, level, cs_n, a0, wr_n, dout
    );

    modport slave (
        input  req_valid, req_reg, req_data, flush,
        output req_ready, busy, level, cs_n, a0, wr_n, dout
    );

endinterface

// File: rtl/saa1099_bus_writer_fifo.sv
// saa1099_req_fifo: synchronous request FIFO, no same-cycle write-to-read bypass
// Ports:
//   clk_sys, rst_n      clock, synchronous active-low reset
//   i_push, i_din       write an entry (ignored when full)
//   i_pop               drop the head entry (ignored when empty)
//   i_clear             empty the FIFO; overrides push and pop
//   o_dout              head entry
//   o_full, o_empty     occupancy flags
//   o_level             occupancy, 0..DEPTH
module saa1099_req_fifo
    import saa1099_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  saa_wr_req_t            i_din,
    input  logic                   i_pop,
    input  logic                   i_clear,
    output saa_wr_req_t            o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    saa_wr_req_t r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    // full blocks a push even when a pop happens in the same cycle
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_level == (AW+1)'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rp];

    always_ff @(posedge clk_sys) begin
        if (w_push && !i_clear) r_mem[r_wp] <= i_din;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n || i_clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            r_wp    <= w_push ? r_wp + 1'b1 : r_wp;
            r_rp    <= w_pop ? r_rp + 1'b1 : r_rp;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/saa1099_bus_writer.sv
// saa1099_bus_writer: queues SAA1099 register writes and serialises them onto the chip bus
// Ports:
//   clk_sys  system clock
//   rst_n    synchronous active-low reset, shared with the saa1099
//   bus      slave side of saa1099_bus_writer_if: request stream, flush, busy/level,
//            and the registered chip bus cs_n/a0/wr_n/dout
module saa1099_bus_writer
    import saa1099_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SETUP_CYC  = 1,
    parameter int WR_LOW_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter bit SKIP_ADDR  = 1'b1
) (
    input logic                 clk_sys,
    input logic                 rst_n,
    saa1099_bus_writer_if.slave bus
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(max3(SETUP_CYC, WR_LOW_CYC, HOLD_CYC)) + 1;

    saa_bus_state_t r_state;
    saa_phase_t     r_phase;
    saa_wr_req_t    r_req;
    logic           r_pend;
    logic [CW-1:0]  r_cnt;
    logic [4:0]     r_cache_reg;
    logic           r_cache_vld;
    logic           r_cs_n;
    logic           r_a0;
    logic           r_wr_n;
    logic [7:0]     r_dout;
    saa_wr_req_t    w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_hit;
    logic [LW-1:0]  w_level;
    logic [CW-1:0]  w_cnt_inc;

    // flush discards a coincident push and keeps the head from being popped
    assign w_push    = bus.req_valid && !w_full && !bus.flush;
    assign w_pop     = r_state == IDLE && !r_pend && !w_empty && !bus.flush;
    assign w_hit     = SKIP_ADDR && r_cache_vld && r_req.addr == r_cache_reg;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    assign bus.req_ready = !w_full;
    assign bus.busy      = !w_empty || r_pend || r_state != IDLE;
    assign bus.level     = w_level;
    assign bus.cs_n      = r_cs_n;
    assign bus.a0        = r_a0;
    assign bus.wr_n      = r_wr_n;
    assign bus.dout      = r_dout;

    saa1099_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   ('{addr: bus.req_reg, data: bus.req_data}),
        .i_pop   (w_pop),
        .i_clear (bus.flush),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // The head is popped into r_req in IDLE and the bus cycle starts on the following edge;
    // a popped request counts as in progress and survives a later flush.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_phase     <= PH_ADDR;
            r_req       <= '0;
            r_pend      <= 1'b0;
            r_cnt       <= CW'(1);
            r_cache_reg <= '0;
            r_cache_vld <= 1'b0;
            r_cs_n      <= 1'b1;
            r_a0        <= 1'b1;
            r_wr_n      <= 1'b1;
            r_dout      <= '0;
        end else begin
            if (w_pop) begin
                r_req  <= w_head;
                r_pend <= 1'b1;
            end
            case (r_state)
                IDLE: if (r_pend) begin
                    r_state <= SETUP;
                    r_pend  <= 1'b0;
                    r_phase <= w_hit ? PH_DATA : PH_ADDR;
                    r_cs_n  <= 1'b0;
                    r_a0    <= !w_hit;
                    r_dout  <= w_hit ? r_req.data : {3'b000, r_req.addr};
                    r_cnt   <= CW'(1);
                end
                SETUP: if (r_cnt >= CW'(SETUP_CYC)) begin
                    r_state <= STROBE;
                    r_wr_n  <= 1'b0;
                    r_cnt   <= CW'(1);
                end else begin
                    r_cnt <= w_cnt_inc;
                end
                STROBE: if (r_cnt >= CW'(WR_LOW_CYC)) begin
                    r_state <= HOLD;
                    r_wr_n  <= 1'b1;
                    r_cnt   <= CW'(1);
                end else begin
                    r_cnt <= w_cnt_inc;
                end
                HOLD: if (r_cnt < CW'(HOLD_CYC)) begin
                    r_cnt <= w_cnt_inc;
                end else if (r_phase == PH_ADDR) begin
                    // cs_n stays low straight into the data phase
                    r_cache_reg <= r_req.addr;
                    r_cache_vld <= 1'b1;
                    r_phase     <= PH_DATA;
                    r_state     <= SETUP;
                    r_a0        <= 1'b0;
                    r_dout      <= r_req.data;
                    r_cnt       <= CW'(1);
                end else begin
                    r_state <= IDLE;
                    r_cs_n  <= 1'b1;
                    r_a0    <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
            // placed last so a flush beats a coincident cache fill
            if (bus.flush) r_cache_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_saa1099_bus_writer.sv
// tb_saa1099_bus_writer: directed and table-driven checks of saa1099_bus_writer against a bus-level saa1099 model
module tb_saa1099_bus_writer;
    import saa1099_pkg::*;

    typedef struct {
        logic [4:0] r;
        logic [7:0] d;
        int         n;
    } vec_t;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    saa1099_bus_writer_if #(.FIFO_DEPTH(8)) bus ();

    saa1099_bus_writer #(
        .FIFO_DEPTH (8),
        .SETUP_CYC  (1),
        .WR_LOW_CYC (2),
        .HOLD_CYC   (1),
        .SKIP_ADDR  (1'b1)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int         tests = 0;
    int         fails = 0;
    int         viol  = 0;
    logic [7:0] mirror  [32];
    logic [7:0] exp_reg [32];
    logic [4:0] latch   = 5'h00;
    logic       prev_wr = 1'b1;
    logic [7:0] prev_dout = 8'h00;
    logic [8:0] log_q [$];

    // saa1099 model: captures on the falling edge of wr_n while selected
    always @(negedge clk_sys) begin
        if (!rst_n) begin
            foreach (mirror[i]) mirror[i] = 8'h00;
            latch = 5'h00;
        end else if (!bus.cs_n && !bus.wr_n && prev_wr) begin
            log_q.push_back({bus.a0, bus.dout});
            if (bus.a0) latch = bus.dout[4:0];
            else mirror[latch] = bus.dout;
        end
        if (!bus.wr_n && !prev_wr && bus.dout != prev_dout) viol++;
        if (!bus.wr_n && bus.cs_n) viol++;
        prev_wr   = bus.wr_n;
        prev_dout = bus.dout;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [7:0] d);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_reg   = r;
        bus.req_data  = d;
        while (!bus.req_ready && n < 200) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        if (n >= 200) check("push_timeout", n, 0);
        @(posedge clk_sys);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_sys);
        while ((bus.busy || !bus.cs_n) && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 1000) check("idle_timeout", n, 0);
    endtask

    function automatic int count_data(input int b);
        int c = 0;
        for (int j = b; j < log_q.size(); j++) if (!log_q[j][8]) c++;
        return c;
    endfunction

    function automatic logic [8:0] entry(input int j);
        return (j < log_q.size()) ? log_q[j] : 9'h1FF;
    endfunction

    initial begin
        vec_t       tbl [8];
        int         base;
        int         n;
        logic [4:0] r;
        logic [7:0] d;
        logic [10:0] e;
        tbl[0] = '{r: SAA_ENV0,  d: 8'h82, n: 2};
        tbl[1] = '{r: SAA_ENV0,  d: 8'h8C, n: 1};
        tbl[2] = '{r: SAA_CTRL,  d: 8'h02, n: 2};
        tbl[3] = '{r: SAA_CTRL,  d: 8'h00, n: 1};
        tbl[4] = '{r: SAA_FREQ0, d: 8'h11, n: 2};
        tbl[5] = '{r: SAA_AMP0,  d: 8'hFF, n: 2};
        tbl[6] = '{r: SAA_AMP0,  d: 8'h00, n: 1};
        tbl[7] = '{r: 5'h1F,     d: 8'hA5, n: 2};
        bus.req_valid = 1'b0;
        bus.req_reg   = 5'h00;
        bus.req_data  = 8'h00;
        bus.flush     = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 rst_n = 1'b1;
        @(negedge clk_sys);
        check("reset_cs_n",  bus.cs_n, 1);
        check("reset_wr_n",  bus.wr_n, 1);
        check("reset_a0",    bus.a0, 1);
        check("reset_dout",  bus.dout, 0);
        check("reset_busy",  bus.busy, 0);
        check("reset_level", bus.level, 0);
        check("reset_ready", bus.req_ready, 1);
        // single write: k counts edges after the accepting edge
        push(SAA_FREQ0, 8'h5A);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_sys);
            e = {1'(!(k >= 2 && k <= 9)), 1'(!(k >= 6 && k <= 9)),
                 1'(!(k == 3 || k == 4 || k == 7 || k == 8)),
                 (k < 2) ? 8'h00 : ((k < 6) ? 8'h08 : 8'h5A)};
            check($sformatf("trace_k%0d", k), {bus.cs_n, bus.a0, bus.wr_n, bus.dout}, e);
        end
        wait_idle();
        check("trace_mirror", mirror[SAA_FREQ0], 8'h5A);
        for (int i = 0; i < 8; i++) begin
            base = log_q.size();
            push(tbl[i].r, tbl[i].d);
            wait_idle();
            check($sformatf("tbl%0d_strobes", i), log_q.size() - base, tbl[i].n);
            check($sformatf("tbl%0d_first", i), entry(base),
                  (tbl[i].n == 2) ? {1'b1, 3'b000, tbl[i].r} : {1'b0, tbl[i].d});
            check($sformatf("tbl%0d_mirror", i), mirror[tbl[i].r], tbl[i].d);
        end
        // fill: one entry is popped, so eight sit queued after the ninth push
        base = log_q.size();
        for (int i = 0; i < 9; i++) push(5'(i + 1), 8'(8'h40 + i));
        check("fill_level", bus.level, 8);
        check("fill_ready", bus.req_ready, 0);
        wait_idle();
        check("fill_strobes", log_q.size() - base, 18);
        for (int j = 0; j < 18; j++)
            check($sformatf("fill_order%0d", j), entry(base + j),
                  (j % 2 == 0) ? {1'b1, 3'b000, 5'(j / 2 + 1)} : {1'b0, 8'(8'h40 + j / 2)});
        // flush while the third request strobes its data phase
        base = log_q.size();
        for (int i = 0; i < 5; i++) push(5'(SAA_OCT10 + i), 8'(8'h20 + i));
        n = 0;
        while (count_data(base) < 3 && n < 500) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        if (n >= 500) check("flush_wait_timeout", n, 0);
        check("flush_in_strobe", bus.wr_n, 0);
        bus.flush = 1'b1;
        @(posedge clk_sys);
        #1;
        bus.flush = 1'b0;
        check("flush_level", bus.level, 0);
        wait_idle();
        check("flush_data_count", count_data(base), 3);
        check("flush_last", entry(log_q.size() - 1), {1'b0, 8'h22});
        check("flush_dropped", mirror[SAA_OCT10 + 5'd3], 8'h00);
        base = log_q.size();
        push(SAA_OCT10 + 5'd2, 8'h99);
        wait_idle();
        check("flush_next_strobes", log_q.size() - base, 2);
        check("flush_next_addr", entry(base), {1'b1, 3'b000, SAA_OCT10 + 5'd2});
        check("flush_next_mirror", mirror[SAA_OCT10 + 5'd2], 8'h99);
        // reset during the data-only strobe of a cached write
        base = log_q.size();
        push(5'h05, 8'h33);
        push(5'h05, 8'h44);
        n = 0;
        while (log_q.size() - base < 3 && n < 500) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        if (n >= 500) check("rst_wait_timeout", n, 0);
        check("rst_in_strobe", bus.wr_n, 0);
        rst_n = 1'b0;
        @(posedge clk_sys);
        #1;
        check("rst_cs_n",  bus.cs_n, 1);
        check("rst_wr_n",  bus.wr_n, 1);
        check("rst_a0",    bus.a0, 1);
        check("rst_level", bus.level, 0);
        check("rst_busy",  bus.busy, 0);
        @(posedge clk_sys);
        #1 rst_n = 1'b1;
        base = log_q.size();
        push(5'h05, 8'h77);
        wait_idle();
        check("rst_next_strobes", log_q.size() - base, 2);
        check("rst_next_addr", entry(base), {1'b1, 3'b000, 5'h05});
        check("rst_next_mirror", mirror[5'h05], 8'h77);
        // random scoreboard, biased towards low registers for cache hits
        foreach (exp_reg[i]) exp_reg[i] = mirror[i];
        for (int i = 0; i < 200; i++) begin
            r = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            d = 8'($urandom);
            push(r, d);
            exp_reg[r] = d;
        end
        wait_idle();
        for (int i = 0; i < 32; i++) check($sformatf("rand_reg%0d", i), mirror[i], exp_reg[i]);
        check("dout_stable_in_strobe", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
